reset_sequencer: RTL and testbench

First stage inside top_level, directly downstream of the bench-level clk/reset drivers. It stretches the incoming synchronous reset, then releases NUM_STAGES downstream reset domains one at a time at fixed spacing, so later logic sees an ordered, glitch-free bring-up. It also accepts a one-cycle soft-reset request that re-runs the full sequence, and counts those requests for debug.

---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/reset_sequencer_if.sv | 30 +++
 rtl/reset_sequencer.sv | 147 ++++++++++++++
 tb/tb_reset_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

  localparam int SOFT_CNT_W = 8;

  // Counter width large enough to hold either the stretch or the gap limit.
  function automatic int cnt_width(input int stretch, input int gap);
    return $clog2(stretch + gap) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Soft-reset request and sequenced reset outputs, bundled for the sequencer.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3
);

  logic                  soft_reset_req;
  logic [NUM_STAGES-1:0] stage_reset_out;
  logic                  all_released;
  logic                  seq_busy;
  logic [SOFT_CNT_W-1:0] soft_reset_count;

  modport master (
    output soft_reset_req,
    input  stage_reset_out,
    input  all_released,
    input  seq_busy,
    input  soft_reset_count
  );

  modport slave (
    input  soft_reset_req,
    output stage_reset_out,
    output all_released,
    output seq_busy,
    output soft_reset_count
  );

endinterface

// File: rtl/reset_sequencer.sv
// Stretches the incoming reset, then releases NUM_STAGES downstream reset
// domains one at a time. A soft-reset request re-runs the whole sequence and
// is counted (saturating) for debug. Every output comes straight from a flop.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 8
) (
  input  logic                clk,
  input  logic                reset,
  reset_sequencer_if.slave    bus
);

  localparam int CNT_W = cnt_width(STRETCH_CYCLES, STAGE_GAP);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0]      STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]      STAGE_LAST   = IDX_W'(NUM_STAGES - 1);
  localparam logic [SOFT_CNT_W-1:0] SOFT_MAX     = '1;

  // Reject parameter sets that would make the sequence meaningless.
  if (NUM_STAGES < 1) begin : g_bad_stages
    $fatal(1, "reset_sequencer: NUM_STAGES must be >= 1");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_stretch
    $fatal(1, "reset_sequencer: STRETCH_CYCLES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $fatal(1, "reset_sequencer: STAGE_GAP must be >= 1");
  end

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      stage_idx_q, stage_idx_d;
  logic [NUM_STAGES-1:0] stage_reset_q, stage_reset_d;
  logic                  all_released_q, all_released_d;
  logic                  seq_busy_q, seq_busy_d;
  logic [SOFT_CNT_W-1:0] soft_cnt_q, soft_cnt_d;
  logic                  soft_req_q;
  logic                  release_fire;

  // State register: reset forces the power-on picture; otherwise take next values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= HOLD;
      cnt_q          <= '0;
      stage_idx_q    <= '0;
      stage_reset_q  <= '1;
      all_released_q <= 1'b0;
      seq_busy_q     <= 1'b1;
      soft_cnt_q     <= '0;
      soft_req_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stage_idx_q    <= stage_idx_d;
      stage_reset_q  <= stage_reset_d;
      all_released_q <= all_released_d;
      seq_busy_q     <= seq_busy_d;
      soft_cnt_q     <= soft_cnt_d;
      soft_req_q     <= bus.soft_reset_req;
    end
  end

  // Next state: soft request restarts from HOLD; otherwise count out stretch and gaps.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_idx_d  = stage_idx_q;
    release_fire = 1'b0;
    if (bus.soft_reset_req) begin
      state_d     = HOLD;
      cnt_d       = '0;
      stage_idx_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == STRETCH_LAST) begin
            release_fire = 1'b1;
            cnt_d        = '0;
            stage_idx_d  = IDX_W'(1);
            state_d      = (NUM_STAGES == 1) ? RUN : RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            release_fire = 1'b1;
            cnt_d        = '0;
            stage_idx_d  = stage_idx_q + 1'b1;
            if (stage_idx_q == STAGE_LAST) begin
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d     = HOLD;
          cnt_d       = '0;
          stage_idx_d = '0;
        end
      endcase
    end
  end

  // Outputs: re-assert everything on a soft request, drop one stage per release,
  // and count only the rising edge of the request.
  always_comb begin
    stage_reset_d  = stage_reset_q;
    all_released_d = all_released_q;
    seq_busy_d     = seq_busy_q;
    soft_cnt_d     = soft_cnt_q;
    if (bus.soft_reset_req) begin
      stage_reset_d  = '1;
      all_released_d = 1'b0;
      seq_busy_d     = 1'b1;
      if (!soft_req_q && (soft_cnt_q != SOFT_MAX)) begin
        soft_cnt_d = soft_cnt_q + 1'b1;
      end
    end else if (release_fire) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (i == int'(stage_idx_q)) begin
          stage_reset_d[i] = 1'b0;
        end
      end
      if (state_d == RUN) begin
        stage_reset_d  = '0;
        all_released_d = 1'b1;
        seq_busy_d     = 1'b0;
      end
    end
  end

  assign bus.stage_reset_out  = stage_reset_q;
  assign bus.all_released     = all_released_q;
  assign bus.seq_busy         = seq_busy_q;
  assign bus.soft_reset_count = soft_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a 1-stage,
// 1-cycle-stretch corner instance sharing the same clock.
module tb_reset_sequencer;

  logic clk;
  logic reset;
  logic reset2;
  int   checks;
  int   errors;
  int   edge_k;

  reset_sequencer_if #(.NUM_STAGES(3)) bif ();
  reset_sequencer_if #(.NUM_STAGES(1)) bif2 ();

  reset_sequencer #(
    .NUM_STAGES(3), .STRETCH_CYCLES(16), .STAGE_GAP(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );

  reset_sequencer #(
    .NUM_STAGES(1), .STRETCH_CYCLES(1), .STAGE_GAP(1)
  ) dut2 (
    .clk(clk), .reset(reset2), .bus(bif2)
  );

  // 20 ns clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Expected stage vector d edges after the sequence base (stretch 16, gap 8).
  function automatic logic [2:0] exp_stage(input int d);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) begin
      v[i] = (d < 16 + 8 * i);
    end
    return v;
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
    edge_k++;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) step();
    reset  = 1'b0;
    edge_k = 0;
  endtask

  task automatic test_reset();
    #191;
    checks++;
    if (bif.stage_reset_out !== 3'b111) begin
      errors++;
      $display("FAIL reset_stage got %b want 111", bif.stage_reset_out);
    end
    checks++;
    if (bif.all_released !== 1'b0 || bif.seq_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags got all=%b busy=%b want all=0 busy=1", bif.all_released, bif.seq_busy);
    end
    checks++;
    if (bif.soft_reset_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", bif.soft_reset_count);
    end
    #9;
    reset  = 1'b0;
    edge_k = 0;
  endtask

  task automatic test_power_on();
    while (edge_k < 32) begin
      step();
      checks++;
      if (bif.stage_reset_out !== exp_stage(edge_k)) begin
        errors++;
        $display("FAIL power_on_stage edge %0d got %b want %b", edge_k, bif.stage_reset_out, exp_stage(edge_k));
      end
      checks++;
      if (bif.all_released !== (edge_k >= 32) || bif.seq_busy !== (edge_k < 32)) begin
        errors++;
        $display("FAIL power_on_flags edge %0d got all=%b busy=%b", edge_k, bif.all_released, bif.seq_busy);
      end
    end
  endtask

  task automatic test_soft_in_run();
    while (edge_k < 39) step();
    bif.soft_reset_req = 1'b1;
    step();
    bif.soft_reset_req = 1'b0;
    checks++;
    if (bif.stage_reset_out !== 3'b111 || bif.seq_busy !== 1'b1 || bif.all_released !== 1'b0) begin
      errors++;
      $display("FAIL soft_run_entry got %b busy=%b all=%b want 111 1 0", bif.stage_reset_out, bif.seq_busy, bif.all_released);
    end
    checks++;
    if (bif.soft_reset_count !== 8'd1) begin
      errors++;
      $display("FAIL soft_run_count got %0d want 1", bif.soft_reset_count);
    end
    while (edge_k < 72) begin
      step();
      checks++;
      if (bif.stage_reset_out !== exp_stage(edge_k - 40) || bif.all_released !== (edge_k >= 72)) begin
        errors++;
        $display("FAIL soft_run_seq edge %0d got %b all=%b want %b", edge_k, bif.stage_reset_out, bif.all_released, exp_stage(edge_k - 40));
      end
    end
  endtask

  task automatic test_soft_mid_release();
    apply_reset();
    while (edge_k < 19) step();
    checks++;
    if (bif.stage_reset_out !== 3'b110) begin
      errors++;
      $display("FAIL mid_pre got %b want 110", bif.stage_reset_out);
    end
    bif.soft_reset_req = 1'b1;
    step();
    bif.soft_reset_req = 1'b0;
    checks++;
    if (bif.stage_reset_out !== 3'b111 || bif.soft_reset_count !== 8'd1) begin
      errors++;
      $display("FAIL mid_entry got %b cnt=%0d want 111 cnt=1", bif.stage_reset_out, bif.soft_reset_count);
    end
    while (edge_k < 52) begin
      step();
      checks++;
      if (bif.stage_reset_out !== exp_stage(edge_k - 20) || bif.seq_busy !== (edge_k < 52)) begin
        errors++;
        $display("FAIL mid_seq edge %0d got %b busy=%b want %b", edge_k, bif.stage_reset_out, bif.seq_busy, exp_stage(edge_k - 20));
      end
    end
  endtask

  task automatic test_held_soft();
    bif.soft_reset_req = 1'b1;
    repeat (10) begin
      step();
      checks++;
      if (bif.stage_reset_out !== 3'b111 || bif.seq_busy !== 1'b1) begin
        errors++;
        $display("FAIL held_stage edge %0d got %b busy=%b want 111 1", edge_k, bif.stage_reset_out, bif.seq_busy);
      end
    end
    bif.soft_reset_req = 1'b0;
    checks++;
    if (bif.soft_reset_count !== 8'd2) begin
      errors++;
      $display("FAIL held_count got %0d want 2", bif.soft_reset_count);
    end
    while (edge_k < 94) begin
      step();
      checks++;
      if (bif.stage_reset_out !== exp_stage(edge_k - 62) || bif.all_released !== (edge_k >= 94)) begin
        errors++;
        $display("FAIL held_seq edge %0d got %b all=%b want %b", edge_k, bif.stage_reset_out, bif.all_released, exp_stage(edge_k - 62));
      end
    end
  endtask

  task automatic test_reset_dominance();
    reset              = 1'b1;
    bif.soft_reset_req = 1'b1;
    repeat (3) step();
    checks++;
    if (bif.soft_reset_count !== 8'd0 || bif.stage_reset_out !== 3'b111) begin
      errors++;
      $display("FAIL dominance_during got cnt=%0d stage=%b want 0 111", bif.soft_reset_count, bif.stage_reset_out);
    end
    reset              = 1'b0;
    bif.soft_reset_req = 1'b0;
    edge_k             = 0;
    step();
    checks++;
    if (bif.soft_reset_count !== 8'd0 || bif.stage_reset_out !== 3'b111) begin
      errors++;
      $display("FAIL dominance_after got cnt=%0d stage=%b want 0 111", bif.soft_reset_count, bif.stage_reset_out);
    end
  endtask

  task automatic test_saturation();
    for (int n = 1; n <= 300; n++) begin
      bif.soft_reset_req = 1'b1;
      step();
      bif.soft_reset_req = 1'b0;
      step();
      if (n == 254) begin
        checks++;
        if (bif.soft_reset_count !== 8'd254) begin
          errors++;
          $display("FAIL sat_254 got %0d want 254", bif.soft_reset_count);
        end
      end
    end
    checks++;
    if (bif.soft_reset_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_300 got %0d want 255", bif.soft_reset_count);
    end
  endtask

  task automatic test_corner();
    checks++;
    if (bif2.stage_reset_out !== 1'b1 || bif2.all_released !== 1'b0 || bif2.seq_busy !== 1'b1) begin
      errors++;
      $display("FAIL corner_reset got %b all=%b busy=%b want 1 0 1", bif2.stage_reset_out, bif2.all_released, bif2.seq_busy);
    end
    reset2 = 1'b0;
    step();
    checks++;
    if (bif2.stage_reset_out !== 1'b0 || bif2.all_released !== 1'b1 || bif2.seq_busy !== 1'b0) begin
      errors++;
      $display("FAIL corner_release got %b all=%b busy=%b want 0 1 0", bif2.stage_reset_out, bif2.all_released, bif2.seq_busy);
    end
    bif2.soft_reset_req = 1'b1;
    step();
    bif2.soft_reset_req = 1'b0;
    checks++;
    if (bif2.stage_reset_out !== 1'b1 || bif2.all_released !== 1'b0 || bif2.soft_reset_count !== 8'd1) begin
      errors++;
      $display("FAIL corner_soft got %b all=%b cnt=%0d want 1 0 1", bif2.stage_reset_out, bif2.all_released, bif2.soft_reset_count);
    end
    step();
    checks++;
    if (bif2.stage_reset_out !== 1'b0 || bif2.all_released !== 1'b1) begin
      errors++;
      $display("FAIL corner_rerelease got %b all=%b want 0 1", bif2.stage_reset_out, bif2.all_released);
    end
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    edge_k              = 0;
    reset               = 1'b1;
    reset2              = 1'b1;
    bif.soft_reset_req  = 1'b0;
    bif2.soft_reset_req = 1'b0;
    test_reset();
    test_power_on();
    test_soft_in_run();
    test_soft_mid_release();
    test_held_soft();
    test_reset_dominance();
    test_saturation();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
